// File: rtl/adbg_tap_pkg.sv
// Shared TAP definitions: state encoding, default opcodes, IR capture pattern and the 1149.1 next-state graph.
package adbg_tap_pkg;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'h0,
        TAP_RTI      = 4'h1,
        TAP_SEL_DR   = 4'h2,
        TAP_CAP_DR   = 4'h3,
        TAP_SHIFT_DR = 4'h4,
        TAP_EXIT1_DR = 4'h5,
        TAP_PAUSE_DR = 4'h6,
        TAP_EXIT2_DR = 4'h7,
        TAP_UPD_DR   = 4'h8,
        TAP_SEL_IR   = 4'h9,
        TAP_CAP_IR   = 4'hA,
        TAP_SHIFT_IR = 4'hB,
        TAP_EXIT1_IR = 4'hC,
        TAP_PAUSE_IR = 4'hD,
        TAP_EXIT2_IR = 4'hE,
        TAP_UPD_IR   = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS   = 2'd0,
        DR_IDCODE   = 2'd1,
        DR_DEBUG    = 2'd2,
        DR_USERCODE = 2'd3
    } dr_sel_e;

    localparam logic [3:0] OP_IDCODE   = 4'b0010;
    localparam logic [3:0] OP_DEBUG    = 4'b1000;
    localparam logic [3:0] OP_USERCODE = 4'b0111;
    localparam logic [3:0] OP_BYPASS   = 4'b1111;

    localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/adbg_tap_fsm.sv
// TAP state register. Strobes are registered from the next state, so each one is a glitch-free
// decode of the current state and is valid for the whole tck period.
module adbg_tap_fsm
    import adbg_tap_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    output tap_state_e state_o,
    output tap_state_e state_next_o,
    output logic       test_logic_reset_o,
    output logic       run_test_idle_o,
    output logic       shift_dr_o,
    output logic       pause_dr_o,
    output logic       update_dr_o,
    output logic       capture_dr_o
);

    tap_state_e state_q;
    tap_state_e state_d;
    logic       tlr_q;
    logic       rti_q;
    logic       shift_dr_q;
    logic       pause_dr_q;
    logic       update_dr_q;
    logic       capture_dr_q;

    // Next state from the 1149.1 graph.
    always_comb begin
        state_d = tap_next(state_q, tms_i);
    end

    // State register and its registered state decodes.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state_q      <= TAP_TLR;
            tlr_q        <= 1'b1;
            rti_q        <= 1'b0;
            shift_dr_q   <= 1'b0;
            pause_dr_q   <= 1'b0;
            update_dr_q  <= 1'b0;
            capture_dr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tlr_q        <= (state_d == TAP_TLR);
            rti_q        <= (state_d == TAP_RTI);
            shift_dr_q   <= (state_d == TAP_SHIFT_DR);
            pause_dr_q   <= (state_d == TAP_PAUSE_DR);
            update_dr_q  <= (state_d == TAP_UPD_DR);
            capture_dr_q <= (state_d == TAP_CAP_DR);
        end
    end

    assign state_o            = state_q;
    assign state_next_o       = state_d;
    assign test_logic_reset_o = tlr_q;
    assign run_test_idle_o    = rti_q;
    assign shift_dr_o         = shift_dr_q;
    assign pause_dr_o         = pause_dr_q;
    assign update_dr_o        = update_dr_q;
    assign capture_dr_o       = capture_dr_q;

endmodule

// File: rtl/adbg_tap_ctrl.sv
// JTAG TAP controller in front of the advanced debug top: IR, IDCODE/BYPASS DRs and the TDO mux.
// Define ADBG_TAP_USERCODE_EN to add the 32-bit USERCODE register.
module adbg_tap_ctrl
    import adbg_tap_pkg::*;
#(
    parameter int                   IR_WIDTH       = 4,
    parameter logic [31:0]          IDCODE_VALUE   = 32'h249511C3,
    parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR   = IR_WIDTH'(OP_IDCODE),
    parameter logic [IR_WIDTH-1:0]  DEBUG_INSTR    = IR_WIDTH'(OP_DEBUG),
    parameter logic [IR_WIDTH-1:0]  USERCODE_INSTR = IR_WIDTH'(OP_USERCODE)
`ifdef ADBG_TAP_USERCODE_EN
    ,parameter logic [31:0]         USERCODE_VALUE = 32'h00000001
`endif
)(
    input  logic                tck_i,
    input  logic                trst_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic                tdo_o,
    output logic                tdo_oe_o,
    input  logic                debug_tdo_i,
    output logic                test_logic_reset_o,
    output logic                run_test_idle_o,
    output logic                shift_dr_o,
    output logic                pause_dr_o,
    output logic                update_dr_o,
    output logic                capture_dr_o,
    output logic                debug_select_o,
    output logic [IR_WIDTH-1:0] ir_o
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = IR_WIDTH'(IR_CAPTURE_PAT);
    localparam logic [IR_WIDTH-1:0] BYPASS_INSTR   = {IR_WIDTH{OP_BYPASS[0]}};

    tap_state_e          state_s;
    tap_state_e          state_next_s;
    dr_sel_e             dr_sel_s;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_d;
    logic                dbg_sel_q;
    logic                bypass_q;
    logic [31:0]         idcode_q;
    logic                tdo_q;
    logic                tdo_d;
    logic                tdo_oe_q;
    logic                tdo_oe_d;
`ifdef ADBG_TAP_USERCODE_EN
    logic [31:0]         usercode_q;
`endif

    adbg_tap_fsm u_fsm (
        .tck_i              (tck_i),
        .trst_i             (trst_i),
        .tms_i              (tms_i),
        .state_o            (state_s),
        .state_next_o       (state_next_s),
        .test_logic_reset_o (test_logic_reset_o),
        .run_test_idle_o    (run_test_idle_o),
        .shift_dr_o         (shift_dr_o),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o),
        .capture_dr_o       (capture_dr_o)
    );

    // IR shift register: capture pattern, then LSB-first shift with tdi into the MSB.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            ir_shift_q <= {IR_WIDTH{1'b0}};
        end else begin
            case (state_s)
                TAP_CAP_IR:   ir_shift_q <= IR_CAPTURE_VAL;
                TAP_SHIFT_IR: ir_shift_q <= {tdi_i, ir_shift_q[IR_WIDTH-1:1]};
                default:      ir_shift_q <= ir_shift_q;
            endcase
        end
    end

    // Latched IR: reloaded on the way into Test-Logic-Reset, otherwise only changed by Update-IR.
    always_comb begin
        if (state_next_s == TAP_TLR) begin
            ir_d = IDCODE_INSTR;
        end else if (state_s == TAP_UPD_IR) begin
            ir_d = ir_shift_q;
        end else begin
            ir_d = ir_q;
        end
    end

    // Latched IR and the debug select derived from it.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            ir_q      <= IDCODE_INSTR;
            dbg_sel_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            dbg_sel_q <= (ir_d == DEBUG_INSTR);
        end
    end

    // DR selection; an explicit BYPASS match wins over any colliding opcode parameter.
    always_comb begin
        if (ir_q == BYPASS_INSTR) begin
            dr_sel_s = DR_BYPASS;
        end else if (ir_q == IDCODE_INSTR) begin
            dr_sel_s = DR_IDCODE;
        end else if (ir_q == DEBUG_INSTR) begin
            dr_sel_s = DR_DEBUG;
`ifdef ADBG_TAP_USERCODE_EN
        end else if (ir_q == USERCODE_INSTR) begin
            dr_sel_s = DR_USERCODE;
`else
        end else if (ir_q == USERCODE_INSTR) begin
            dr_sel_s = DR_BYPASS;
`endif
        end else begin
            dr_sel_s = DR_BYPASS;
        end
    end

    // Local data registers: IDCODE shifts like a 32-bit chain, BYPASS is a single stage.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            idcode_q <= IDCODE_VALUE;
            bypass_q <= 1'b0;
        end else begin
            if (state_s == TAP_CAP_DR && dr_sel_s == DR_IDCODE) begin
                idcode_q <= IDCODE_VALUE;
            end else if (state_s == TAP_SHIFT_DR && dr_sel_s == DR_IDCODE) begin
                idcode_q <= {tdi_i, idcode_q[31:1]};
            end else begin
                idcode_q <= idcode_q;
            end
            if (state_s == TAP_CAP_DR && dr_sel_s == DR_BYPASS) begin
                bypass_q <= 1'b0;
            end else if (state_s == TAP_SHIFT_DR && dr_sel_s == DR_BYPASS) begin
                bypass_q <= tdi_i;
            end else begin
                bypass_q <= bypass_q;
            end
        end
    end

`ifdef ADBG_TAP_USERCODE_EN
    // USERCODE register, same shape as IDCODE.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            usercode_q <= USERCODE_VALUE;
        end else if (state_s == TAP_CAP_DR && dr_sel_s == DR_USERCODE) begin
            usercode_q <= USERCODE_VALUE;
        end else if (state_s == TAP_SHIFT_DR && dr_sel_s == DR_USERCODE) begin
            usercode_q <= {tdi_i, usercode_q[31:1]};
        end else begin
            usercode_q <= usercode_q;
        end
    end
`endif

    // TDO source select for the current state.
    always_comb begin
        tdo_d    = 1'b0;
        tdo_oe_d = (state_s == TAP_SHIFT_IR) || (state_s == TAP_SHIFT_DR);
        case (state_s)
            TAP_SHIFT_IR: tdo_d = ir_shift_q[0];
            TAP_SHIFT_DR: begin
                case (dr_sel_s)
                    DR_IDCODE:   tdo_d = idcode_q[0];
                    DR_DEBUG:    tdo_d = debug_tdo_i;
`ifdef ADBG_TAP_USERCODE_EN
                    DR_USERCODE: tdo_d = usercode_q[0];
`endif
                    default:     tdo_d = bypass_q;
                endcase
            end
            default: tdo_d = 1'b0;
        endcase
    end

    // TDO and its enable change on the falling edge so the receiver samples a stable bit.
    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign tdo_o          = tdo_q;
    assign tdo_oe_o       = tdo_oe_q;
    assign debug_select_o = dbg_sel_q;
    assign ir_o           = ir_q;

endmodule

// File: tb/tb_adbg_tap_ctrl.sv
// Self-checking bench for adbg_tap_ctrl: directed scenarios plus a random TMS walk against a queue-based TAP model.
module tb_adbg_tap_ctrl;

    localparam logic [31:0] EXP_IDCODE   = 32'h249511C3;
    localparam logic [31:0] EXP_USERCODE = 32'h00000001;
    localparam logic [3:0]  OP_ID  = 4'b0010;
    localparam logic [3:0]  OP_DBG = 4'b1000;
    localparam logic [3:0]  OP_UC  = 4'b0111;
    localparam logic [3:0]  OP_BYP = 4'b1111;

    localparam int S_TLR = 0,  S_RTI = 1,  S_SDR = 2,   S_CDR = 3,   S_SHDR = 4,  S_E1DR = 5,
                   S_PDR = 6,  S_E2DR = 7, S_UDR = 8,   S_SIR = 9,   S_CIR = 10,  S_SHIR = 11,
                   S_E1IR = 12, S_PIR = 13, S_E2IR = 14, S_UIR = 15;

    logic       tck_i = 1'b0;
    logic       trst_i;
    logic       tms_i;
    logic       tdi_i;
    logic       tdo_o;
    logic       tdo_oe_o;
    logic       debug_tdo_i;
    logic       test_logic_reset_o;
    logic       run_test_idle_o;
    logic       shift_dr_o;
    logic       pause_dr_o;
    logic       update_dr_o;
    logic       capture_dr_o;
    logic       debug_select_o;
    logic [3:0] ir_o;

    int checks = 0;
    int errors = 0;

    adbg_tap_ctrl dut (
        .tck_i              (tck_i),
        .trst_i             (trst_i),
        .tms_i              (tms_i),
        .tdi_i              (tdi_i),
        .tdo_o              (tdo_o),
        .tdo_oe_o           (tdo_oe_o),
        .debug_tdo_i        (debug_tdo_i),
        .test_logic_reset_o (test_logic_reset_o),
        .run_test_idle_o    (run_test_idle_o),
        .shift_dr_o         (shift_dr_o),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o),
        .capture_dr_o       (capture_dr_o),
        .debug_select_o     (debug_select_o),
        .ir_o               (ir_o)
    );

    always #5 tck_i = ~tck_i;

    // ---------------- reference model ----------------
    int         nx0 [16];
    int         nx1 [16];
    int         m_state;
    logic [3:0] m_ir;
    bit         irq [$];
    bit         drq [$];

    task automatic edge_of(input int s, input int n0, input int n1);
        nx0[s] = n0;
        nx1[s] = n1;
    endtask

    task automatic init_graph();
        edge_of(S_TLR,  S_RTI,  S_TLR);
        edge_of(S_RTI,  S_RTI,  S_SDR);
        edge_of(S_SDR,  S_CDR,  S_SIR);
        edge_of(S_CDR,  S_SHDR, S_E1DR);
        edge_of(S_SHDR, S_SHDR, S_E1DR);
        edge_of(S_E1DR, S_PDR,  S_UDR);
        edge_of(S_PDR,  S_PDR,  S_E2DR);
        edge_of(S_E2DR, S_SHDR, S_UDR);
        edge_of(S_UDR,  S_RTI,  S_SDR);
        edge_of(S_SIR,  S_CIR,  S_TLR);
        edge_of(S_CIR,  S_SHIR, S_E1IR);
        edge_of(S_SHIR, S_SHIR, S_E1IR);
        edge_of(S_E1IR, S_PIR,  S_UIR);
        edge_of(S_PIR,  S_PIR,  S_E2IR);
        edge_of(S_E2IR, S_SHIR, S_UIR);
        edge_of(S_UIR,  S_RTI,  S_SDR);
    endtask

    // 0 bypass, 1 idcode, 2 debug, 3 usercode
    function automatic int dr_kind(input logic [3:0] ir);
        if (ir == OP_ID)  return 1;
        if (ir == OP_DBG) return 2;
`ifdef ADBG_TAP_USERCODE_EN
        if (ir == OP_UC)  return 3;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_state = S_TLR;
        m_ir    = OP_ID;
        irq.delete();
        drq.delete();
    endtask

    task automatic model_clock(input logic tms, input logic tdi);
        int k;
        k = dr_kind(m_ir);
        case (m_state)
            S_CIR: begin
                irq.delete();
                irq.push_back(1'b1);
                repeat (3) irq.push_back(1'b0);
            end
            S_SHIR: begin
                void'(irq.pop_front());
                irq.push_back(tdi);
            end
            S_UIR: begin
                for (int i = 0; i < 4; i++) m_ir[i] = irq[i];
            end
            S_CDR: begin
                drq.delete();
                if (k == 1) for (int i = 0; i < 32; i++) drq.push_back(EXP_IDCODE[i]);
                else if (k == 3) for (int i = 0; i < 32; i++) drq.push_back(EXP_USERCODE[i]);
                else if (k == 0) drq.push_back(1'b0);
            end
            S_SHDR: begin
                if (k != 2) begin
                    void'(drq.pop_front());
                    drq.push_back(tdi);
                end
            end
            default: ;
        endcase
        m_state = tms ? nx1[m_state] : nx0[m_state];
        if (m_state == S_TLR) m_ir = OP_ID;
    endtask

    function automatic logic exp_tdo();
        if (m_state == S_SHIR) return irq[0];
        if (m_state == S_SHDR) return (dr_kind(m_ir) == 2) ? debug_tdo_i : drq[0];
        return 1'b0;
    endfunction

    function automatic logic [5:0] exp_strobes();
        return {m_state == S_TLR, m_state == S_RTI, m_state == S_SHDR,
                m_state == S_PDR, m_state == S_UDR, m_state == S_CDR};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic tms, input logic tdi, input logic dtdo);
        tms_i       = tms;
        tdi_i       = tdi;
        debug_tdo_i = dtdo;
        @(posedge tck_i);
        model_clock(tms, tdi);
        @(negedge tck_i);
        #1;
    endtask

    task automatic shift_ir(input logic [3:0] din, output logic [3:0] dout);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dout[i] = tdo_o;
            tick(i == 3, din[i], 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic shift_dr(input logic [31:0] din, input logic [31:0] dbg, input int n,
                            output logic [31:0] dout);
        dout = 32'h0;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, dbg[0]);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo_o;
            tick(i == n - 1, din[i], (i + 1 < 32) ? dbg[i+1] : 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [5:0] strobes();
        return {test_logic_reset_o, run_test_idle_o, shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        trst_i = 1'b1; tms_i = 1'b1; tdi_i = 1'b0; debug_tdo_i = 1'b0;
        repeat (2) @(negedge tck_i);
        #1;
        checks++;
        if (strobes() !== 6'b100000) begin
            errors++; $display("FAIL reset_strobes got %b want %b", strobes(), 6'b100000);
        end
        checks++;
        if (ir_o !== OP_ID || debug_select_o !== 1'b0) begin
            errors++; $display("FAIL reset_ir got ir=%b dbg=%b want ir=%b dbg=0", ir_o, debug_select_o, OP_ID);
        end
        checks++;
        if (tdo_o !== 1'b0 || tdo_oe_o !== 1'b0) begin
            errors++; $display("FAIL reset_tdo got tdo=%b oe=%b want 0 0", tdo_o, tdo_oe_o);
        end
        trst_i = 1'b0;
        model_reset();
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (test_logic_reset_o !== 1'b1) begin
            errors++; $display("FAIL reset_hold got %b want 1", test_logic_reset_o);
        end
    endtask

    task automatic test_idcode();
        logic [31:0] dout;
        logic [31:0] oe_v;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (tdo_oe_o !== 1'b0) begin
            errors++; $display("FAIL idcode_oe_capture got %b want 0", tdo_oe_o);
        end
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            dout[i] = tdo_o;
            oe_v[i] = tdo_oe_o;
            tick(i == 31, 1'($urandom_range(0, 1)), 1'b0);
        end
        checks++;
        if (dout !== EXP_IDCODE) begin
            errors++; $display("FAIL idcode_value got %h want %h", dout, EXP_IDCODE);
        end
        checks++;
        if (oe_v !== 32'hFFFFFFFF || tdo_oe_o !== 1'b0) begin
            errors++; $display("FAIL idcode_oe got %h/%b want ffffffff/0", oe_v, tdo_oe_o);
        end
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_tlr_from_rti();
        logic [3:0] d;
        tick(1'b0, 1'b0, 1'b0);
        shift_ir(OP_DBG, d);
        checks++;
        if (run_test_idle_o !== 1'b1 || ir_o !== OP_DBG) begin
            errors++; $display("FAIL tlr_pre got rti=%b ir=%b want 1 %b", run_test_idle_o, ir_o, OP_DBG);
        end
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (test_logic_reset_o !== 1'b1 || ir_o !== OP_ID || debug_select_o !== 1'b0) begin
            errors++; $display("FAIL tlr_five got tlr=%b ir=%b dbg=%b want 1 %b 0",
                               test_logic_reset_o, ir_o, debug_select_o, OP_ID);
        end
    endtask

    task automatic test_ir_capture();
        logic [3:0] d;
        tick(1'b0, 1'b0, 1'b0);
        shift_ir(OP_BYP, d);
        checks++;
        if (ir_o !== OP_BYP || debug_select_o !== 1'b0) begin
            errors++; $display("FAIL ir_load got ir=%b dbg=%b want %b 0", ir_o, debug_select_o, OP_BYP);
        end
        shift_ir(OP_BYP, d);
        checks++;
        if (d !== 4'b0001) begin
            errors++; $display("FAIL ir_capture got %b want 0001", d);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] dout;
        logic [31:0] din;
        tick(1'b0, 1'b0, 1'b0);
        shift_dr(32'h0000000D, 32'h0, 4, dout);
        checks++;
        if (dout[3:0] !== 4'b1010) begin
            errors++; $display("FAIL bypass_1011 got %b want 1010", dout[3:0]);
        end
        din = $urandom();
        shift_dr(din, 32'h0, 20, dout);
        checks++;
        if (dout[19:0] !== ((din << 1) & 32'h000FFFFF)) begin
            errors++; $display("FAIL bypass_rand got %h want %h", dout[19:0], (din << 1) & 32'h000FFFFF);
        end
    endtask

    task automatic test_debug();
        logic [3:0]  d;
        logic [31:0] dout;
        logic [31:0] dbg;
        logic        walk_tms [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [5:0]  walk_exp [12] = '{6'b000000, 6'b000001, 6'b001000, 6'b001000, 6'b000000, 6'b000100,
                                       6'b000100, 6'b000000, 6'b001000, 6'b000000, 6'b000010, 6'b010000};
        tick(1'b0, 1'b0, 1'b0);
        shift_ir(OP_DBG, d);
        checks++;
        if (debug_select_o !== 1'b1 || ir_o !== OP_DBG) begin
            errors++; $display("FAIL debug_select got %b ir=%b want 1 %b", debug_select_o, ir_o, OP_DBG);
        end
        for (int i = 0; i < 12; i++) begin
            tick(walk_tms[i], 1'b0, 1'b0);
            checks++;
            if (strobes() !== walk_exp[i] || debug_select_o !== 1'b1) begin
                errors++; $display("FAIL debug_strobe step %0d got %b/%b want %b/1",
                                   i, strobes(), debug_select_o, walk_exp[i]);
            end
        end
        dbg = $urandom();
        shift_dr($urandom(), dbg, 16, dout);
        checks++;
        if (dout[15:0] !== dbg[15:0]) begin
            errors++; $display("FAIL debug_mirror got %h want %h", dout[15:0], dbg[15:0]);
        end
        // new opcode shifted in but not yet updated
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, OP_ID[i], 1'b0);
        checks++;
        if (ir_o !== OP_DBG || debug_select_o !== 1'b1) begin
            errors++; $display("FAIL debug_exit1ir got ir=%b dbg=%b want %b 1", ir_o, debug_select_o, OP_DBG);
        end
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (ir_o !== OP_DBG) begin
            errors++; $display("FAIL debug_updir got %b want %b", ir_o, OP_DBG);
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (ir_o !== OP_ID || debug_select_o !== 1'b0) begin
            errors++; $display("FAIL debug_after_upd got ir=%b dbg=%b want %b 0", ir_o, debug_select_o, OP_ID);
        end
    endtask

    task automatic test_usercode();
        logic [3:0]  d;
        logic [31:0] dout;
        logic [31:0] din;
        logic [31:0] want;
        tick(1'b0, 1'b0, 1'b0);
        shift_ir(OP_UC, d);
        din = $urandom();
        shift_dr(din, 32'h0, 32, dout);
`ifdef ADBG_TAP_USERCODE_EN
        want = EXP_USERCODE;
`else
        want = din << 1;
`endif
        checks++;
        if (dout !== want) begin
            errors++; $display("FAIL usercode got %h want %h", dout, want);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [3:0] d;
        tick(1'b0, 1'b0, 1'b0);
        shift_ir(OP_BYP, d);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (shift_dr_o !== 1'b1 || tdo_oe_o !== 1'b1) begin
            errors++; $display("FAIL midshift_pre got shift=%b oe=%b want 1 1", shift_dr_o, tdo_oe_o);
        end
        trst_i = 1'b1;
        #1;
        checks++;
        if (strobes() !== 6'b100000 || ir_o !== OP_ID || tdo_oe_o !== 1'b0 || tdo_o !== 1'b0) begin
            errors++; $display("FAIL midshift_reset got st=%b ir=%b oe=%b tdo=%b want 100000 %b 0 0",
                               strobes(), ir_o, tdo_oe_o, tdo_o, OP_ID);
        end
        @(negedge tck_i);
        #1;
        trst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic [3:0] ops [5];
        logic       tms;
        logic       tdi;
        ops = '{OP_ID, OP_DBG, OP_UC, OP_BYP, 4'b0101};
        for (int n = 0; n < 800; n++) begin
            if (n % 64 == 0) begin
                repeat (5) tick(1'b1, 1'b0, 1'b0);
                tick(1'b0, 1'b0, 1'b0);
                shift_ir(ops[$urandom_range(0, 4)], d);
            end
            tms = ($urandom_range(0, 99) < 30);
            tdi = 1'($urandom_range(0, 1));
            tick(tms, tdi, 1'($urandom_range(0, 1)));
            checks++;
            if (strobes() !== exp_strobes()) begin
                errors++; $display("FAIL rand_strobes n=%0d got %b want %b", n, strobes(), exp_strobes());
            end
            checks++;
            if (tdo_o !== exp_tdo()) begin
                errors++; $display("FAIL rand_tdo n=%0d got %b want %b", n, tdo_o, exp_tdo());
            end
            checks++;
            if (tdo_oe_o !== (m_state == S_SHIR || m_state == S_SHDR)) begin
                errors++; $display("FAIL rand_oe n=%0d got %b want %b", n, tdo_oe_o,
                                   (m_state == S_SHIR || m_state == S_SHDR));
            end
            checks++;
            if (ir_o !== m_ir || debug_select_o !== (m_ir == OP_DBG)) begin
                errors++; $display("FAIL rand_ir n=%0d got %b/%b want %b/%b", n, ir_o, debug_select_o,
                                   m_ir, (m_ir == OP_DBG));
            end
        end
    endtask

    initial begin
        init_graph();
        model_reset();
        test_reset();
        test_idcode();
        test_tlr_from_rti();
        test_ir_capture();
        test_bypass();
        test_debug();
        test_usercode();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adbg_tap_ctrl.md
Name: adbg_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller that sits directly upstream of the advanced debug top.
- Decodes TMS into the 16-state TAP FSM and holds the instruction register.
- Implements the IDCODE and BYPASS data registers.
- Generates shift/pause/update/capture DR strobes and debug_select for the debug top.
- Multiplexes that block's serial output onto the chip TDO.

Parameters:
- IR_WIDTH, 4, instruction register width (min 2).
- IDCODE_VALUE, 32'h249511C3, value shifted out by IDCODE; bit 0 is 1.
- IDCODE_INSTR, 4'b0010, opcode selecting the IDCODE register.
- DEBUG_INSTR, 4'b1000, opcode selecting the debug chain (asserts debug_select_o).
- USERCODE_INSTR, 4'b0111, opcode for USERCODE (used only with the optional feature).
- BYPASS_INSTR is fixed at all-ones; every unlisted opcode also selects BYPASS.

Ports:
- tck_i  in  1  JTAG clock; the only clock.
- trst_i  in  1  asynchronous active-high reset.
- tms_i  in  1  test mode select, sampled on posedge tck_i.
- tdi_i  in  1  serial data in.
- tdo_o  out  1  serial data out, registered on negedge tck_i.
- tdo_oe_o  out  1  TDO output enable.
- debug_tdo_i  in  1  serial output of the debug top.
- test_logic_reset_o  out  1  FSM in Test-Logic-Reset.
- run_test_idle_o  out  1  FSM in Run-Test/Idle.
- shift_dr_o  out  1  FSM in Shift-DR.
- pause_dr_o  out  1  FSM in Pause-DR.
- update_dr_o  out  1  FSM in Update-DR.
- capture_dr_o  out  1  FSM in Capture-DR.
- debug_select_o  out  1  latched IR == DEBUG_INSTR.
- ir_o  out  IR_WIDTH  latched instruction.

Behaviour:
- Reset:
  - FSM = Test-Logic-Reset; latched IR = IDCODE_INSTR; IR shift reg = 0; bypass reg = 0; IDCODE shift reg = IDCODE_VALUE.
  - tdo_o = 0, tdo_oe_o = 0.
  - test_logic_reset_o = 1; all other strobes 0; debug_select_o = 0; ir_o = IDCODE_INSTR.
- FSM:
  - 16 standard states; the next state depends only on the current state and tms_i (standard 1149.1 graph), updated on posedge.
  - 5 consecutive TMS=1 clocks reach Test-Logic-Reset from any state.
  - Entering Test-Logic-Reset synchronously reloads latched IR = IDCODE_INSTR.
- Strobes:
  - All state outputs are combinational decodes of the registered state: glitch-free and valid for the whole tck period.
  - The debug top samples them on the next posedge (zero added latency).
- IR:
  - Capture-IR loads the shift reg with {0..0,2'b01}.
  - Shift-IR shifts right (LSB out first, tdi_i into MSB).
  - Update-IR copies the shift reg to the latched IR.
  - Exit/Pause states hold the shift reg unchanged.
- DR:
  - Selected by the latched IR.
  - IDCODE: Capture-DR loads IDCODE_VALUE; Shift-DR shifts right, LSB first.
  - BYPASS: Capture-DR loads 0; Shift-DR loads tdi_i (one-cycle delay).
  - DEBUG: no local DR; the debug top owns the shift.
- debug_select_o = (latched IR == DEBUG_INSTR); it changes only at Update-IR or in Test-Logic-Reset.
- TDO:
  - Registered on negedge tck_i.
  - Shift-IR: IR shift reg bit 0.
  - Shift-DR: bit 0 of the selected DR, or debug_tdo_i when DEBUG is selected.
  - Otherwise 0.
- tdo_oe_o: registered on negedge, 1 only while in Shift-IR or Shift-DR.
- Reset mid-shift: asynchronous abort; partially shifted IR is discarded and the latched IR returns to IDCODE.
- Simultaneous events: an opcode shifted in is only effective after Update-IR; a DR shift in progress is never disturbed by IR content.

Optional Feature:
- Macro: ADBG_TAP_USERCODE_EN.
- Parameter USERCODE_VALUE, default 32'h00000001.
- Defined: USERCODE_INSTR selects a 32-bit USERCODE DR, captured with USERCODE_VALUE and shifted LSB first like IDCODE.
- Undefined: USERCODE_INSTR falls into BYPASS, and no USERCODE register or parameter is synthesized.

Decomposition:
- Shared package adbg_tap_pkg holds:
  - the 4-bit TAP state enum (localparam encodings);
  - the default opcodes IDCODE/DEBUG/USERCODE/BYPASS;
  - the IR capture pattern constant.
- One natural sub-module, adbg_tap_fsm: state register plus next-state and state-decode logic. The top holds the IR/DR registers and the TDO mux.

Test Plan:
- Reset/TLR:
  - assert trst_i mid Shift-DR → test_logic_reset_o=1, ir_o=4'b0010, tdo_oe_o=0 immediately.
  - from Run-Test/Idle, 5 clocks TMS=1 → test_logic_reset_o=1.
- IDCODE: after reset, go TLR→Shift-DR, shift 32 bits → TDO sequence LSB-first = 32'h249511C3; tdo_oe_o=1 only during the shift.
- IR capture/bypass:
  - load IR=4'b1111, read IR → first captured bits 1,0,0,0.
  - in Shift-DR, TDI pattern 1011 → TDO 0,1,0,1 (one-cycle delay, leading 0).
- Debug chain:
  - load IR=4'b1000 → debug_select_o=1 after Update-IR.
  - Capture/Shift/Pause/Update-DR strobes each high for exactly the cycles in the state.
  - debug_tdo_i toggling is mirrored on tdo_o delayed by half a tck.
- USERCODE with ADBG_TAP_USERCODE_EN: IR=4'b0111, shift 32 → 32'h00000001.
- USERCODE without the macro: same opcode behaves as bypass (1-bit delay).
